// File: rtl/mips_main_ctrl.sv
// ---------------------------------------------------------------------------
// mips_main_ctrl -- multicycle MIPS main control FSM.
//
// Decodes the instruction opcode and sequences fetch / decode / execute /
// memory / writeback, driving every datapath enable plus the 3-bit alu_op
// code that the downstream ALU control decoder combines with funct.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   opcode[5:0]    IR[31:26]; sampled (and latched) in DECODE
//   mem_ready      memory finished the current access this cycle
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//   pc_source[1:0], alu_op[2:0]   datapath controls
//   illegal_op     unknown opcode seen
//   state          current FSM state (debug)
//
// Memory handshake: mem_read/mem_write act as a request that is held while
// the FSM sits in FETCH, MEMRD or MEMWR; the access completes on the rising
// edge where mem_ready=1, and only then does the FSM leave that state.
// mem_ready is ignored in every other state.
//
// Optional build macro: ILLEGAL_TRAP_EN
//   defined   -> unknown opcode parks the FSM in TRAP with illegal_op=1
//   undefined -> unknown opcode is a NOP; illegal_op pulses in the next FETCH
// ---------------------------------------------------------------------------
module mips_main_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [2:0]         alu_op,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        ST_RST    = 'd0,
        ST_FETCH  = 'd1,
        ST_DECODE = 'd2,
        ST_MEMADR = 'd3,
        ST_MEMRD  = 'd4,
        ST_MEMWB  = 'd5,
        ST_MEMWR  = 'd6,
        ST_REXEC  = 'd7,
        ST_RWB    = 'd8,
        ST_BRANCH = 'd9,
        ST_JUMP   = 'd10,
        ST_IEXEC  = 'd11,
        ST_IWB    = 'd12,
        ST_TRAP   = 'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] opcode_q;   // opcode captured in DECODE; later IR changes ignored

    // ---------------------------------------------------------------------
    // State and opcode registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RST;
            opcode_q <= 6'h00;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                opcode_q <= opcode;
            end
        end
    end

`ifndef ILLEGAL_TRAP_EN
    // Set for exactly one cycle: the FETCH that follows a DECODE of an
    // unknown opcode (DECODE always goes straight to FETCH in that case).
    logic illegal_q;
    logic decode_unknown;

    always_comb begin
        decode_unknown = 1'b0;
        if (state_q == ST_DECODE) begin
            case (opcode)
                OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
                OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: decode_unknown = 1'b0;
                default:                           decode_unknown = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= decode_unknown;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Next state and Moore outputs (ir_write/pc_write in FETCH gated by
    // mem_ready so the PC and IR load only on the completing cycle).
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_source     = 2'd0;
        alu_op        = 3'd0;
`ifdef ILLEGAL_TRAP_EN
        illegal_op    = 1'b0;
`else
        illegal_op    = illegal_q;
`endif

        case (state_q)
            ST_RST: begin
                state_d    = ST_FETCH;
                illegal_op = 1'b0;
            end
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = 2'd3;   // PC + (imm<<2): branch target precompute
                case (opcode)
                    OP_RTYPE:                         state_d = ST_REXEC;
                    OP_LW, OP_SW:                     state_d = ST_MEMADR;
                    OP_BEQ:                           state_d = ST_BRANCH;
                    OP_J:                             state_d = ST_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_IEXEC;
`ifdef ILLEGAL_TRAP_EN
                    default:                          state_d = ST_TRAP;
`else
                    default:                          state_d = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (opcode_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_REXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'd2;
                state_d   = ST_RWB;
            end
            ST_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                state_d   = ST_FETCH;
            end
            ST_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                case (opcode_q)
                    OP_ANDI: alu_op = 3'd3;
                    OP_ORI:  alu_op = 3'd4;
                    OP_SLTI: alu_op = 3'd5;
                    default: alu_op = 3'd0;
                endcase
                state_d = ST_IWB;
            end
            ST_IWB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: begin
                illegal_op = 1'b1;
                state_d    = ST_TRAP;
            end
`endif
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_main_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_main_ctrl -- directed self-checking bench for mips_main_ctrl.
// Each step checks the state and the packed control vector against
// hand-computed constants, then advances one clock.
// ---------------------------------------------------------------------------
module tb_mips_main_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mips_main_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout:
    // pc_write pc_write_cond iord mem_read mem_write ir_write mem_to_reg
    // reg_dst reg_write alu_src_a alu_src_b[2] pc_source[2] alu_op[3] illegal_op
    logic [18:0] vec;
    assign vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                  pc_source, alu_op, illegal_op};

    localparam logic [18:0] V_ZERO    = 19'b0_0_0_0_0_0_0_0_0_0_00_00_000_0;
    localparam logic [18:0] V_FETCH   = 19'b1_0_0_1_0_1_0_0_0_0_01_00_000_0;
    localparam logic [18:0] V_FETCH_W = 19'b0_0_0_1_0_0_0_0_0_0_01_00_000_0;
    localparam logic [18:0] V_FETCH_I = 19'b1_0_0_1_0_1_0_0_0_0_01_00_000_1;
    localparam logic [18:0] V_DECODE  = 19'b0_0_0_0_0_0_0_0_0_0_11_00_000_0;
    localparam logic [18:0] V_MEMADR  = 19'b0_0_0_0_0_0_0_0_0_1_10_00_000_0;
    localparam logic [18:0] V_MEMRD   = 19'b0_0_1_1_0_0_0_0_0_0_00_00_000_0;
    localparam logic [18:0] V_MEMWB   = 19'b0_0_0_0_0_0_1_0_1_0_00_00_000_0;
    localparam logic [18:0] V_MEMWR   = 19'b0_0_1_0_1_0_0_0_0_0_00_00_000_0;
    localparam logic [18:0] V_REXEC   = 19'b0_0_0_0_0_0_0_0_0_1_00_00_010_0;
    localparam logic [18:0] V_RWB     = 19'b0_0_0_0_0_0_0_1_1_0_00_00_000_0;
    localparam logic [18:0] V_BRANCH  = 19'b0_1_0_0_0_0_0_0_0_1_00_01_001_0;
    localparam logic [18:0] V_JUMP    = 19'b1_0_0_0_0_0_0_0_0_0_00_10_000_0;
    localparam logic [18:0] V_IEX_ORI = 19'b0_0_0_0_0_0_0_0_0_1_10_00_100_0;
    localparam logic [18:0] V_IEX_SLT = 19'b0_0_0_0_0_0_0_0_0_1_10_00_101_0;
    localparam logic [18:0] V_IEX_ADD = 19'b0_0_0_0_0_0_0_0_0_1_10_00_000_0;
    localparam logic [18:0] V_IWB     = 19'b0_0_0_0_0_0_0_0_1_0_00_00_000_0;
    localparam logic [18:0] V_TRAP    = 19'b0_0_0_0_0_0_0_0_0_0_00_00_000_1;

    task automatic check(input string tag, input logic [3:0] exp_state,
                         input logic [18:0] exp_vec);
        total++;
        assert (state === exp_state) else begin
            bad++;
            $error("FAIL %s state obs=%0d exp=%0d", tag, state, exp_state);
        end
        total++;
        assert (vec === exp_vec) else begin
            bad++;
            $error("FAIL %s ctrl obs=%b exp=%b", tag, vec, exp_vec);
        end
    endtask

    // Driver step: inputs are set by the caller; settle, check, advance.
    task automatic step(input string tag, input logic [3:0] exp_state,
                        input logic [18:0] exp_vec);
        #1;
        check(tag, exp_state, exp_vec);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'h00;

        // reset held for 3 cycles
        @(posedge clk); #1;
        step("rst0", 4'd0, V_ZERO);
        step("rst1", 4'd0, V_ZERO);
        rst_n = 1'b1;
        opcode = 6'h23;
        step("rst_rel", 4'd0, V_ZERO);

        // lw: 1,2,3,4,5 ; opcode changed in MEMADR must be ignored
        step("lw_fetch", 4'd1, V_FETCH);
        step("lw_decode", 4'd2, V_DECODE);
        opcode = 6'h2B;
        step("lw_memadr", 4'd3, V_MEMADR);
        step("lw_memrd", 4'd4, V_MEMRD);
        step("lw_memwb", 4'd5, V_MEMWB);

        // R-type with 2 stall cycles in FETCH
        opcode = 6'h00;
        mem_ready = 1'b0;
        step("r_fetch_w0", 4'd1, V_FETCH_W);
        step("r_fetch_w1", 4'd1, V_FETCH_W);
        mem_ready = 1'b1;
        step("r_fetch", 4'd1, V_FETCH);
        step("r_decode", 4'd2, V_DECODE);
        step("r_rexec", 4'd7, V_REXEC);
        step("r_rwb", 4'd8, V_RWB);

        // ori; IR changes during IEXEC are ignored
        opcode = 6'h0D;
        step("ori_fetch", 4'd1, V_FETCH);
        step("ori_decode", 4'd2, V_DECODE);
        opcode = 6'h0A;
        step("ori_iexec", 4'd11, V_IEX_ORI);
        step("ori_iwb", 4'd12, V_IWB);

        // slti
        step("slti_fetch", 4'd1, V_FETCH);
        step("slti_decode", 4'd2, V_DECODE);
        step("slti_iexec", 4'd11, V_IEX_SLT);
        step("slti_iwb", 4'd12, V_IWB);

        // addi
        opcode = 6'h08;
        step("addi_fetch", 4'd1, V_FETCH);
        step("addi_decode", 4'd2, V_DECODE);
        step("addi_iexec", 4'd11, V_IEX_ADD);
        step("addi_iwb", 4'd12, V_IWB);

        // beq: 3 cycles
        opcode = 6'h04;
        step("beq_fetch", 4'd1, V_FETCH);
        step("beq_decode", 4'd2, V_DECODE);
        step("beq_branch", 4'd9, V_BRANCH);

        // j: 3 cycles
        opcode = 6'h02;
        step("j_fetch", 4'd1, V_FETCH);
        step("j_decode", 4'd2, V_DECODE);
        step("j_jump", 4'd10, V_JUMP);

        // sw with stall in MEMWR (mem_ready=0 in MEMADR is ignored), then reset
        opcode = 6'h2B;
        step("sw_fetch", 4'd1, V_FETCH);
        step("sw_decode", 4'd2, V_DECODE);
        mem_ready = 1'b0;
        step("sw_memadr", 4'd3, V_MEMADR);
        step("sw_memwr0", 4'd6, V_MEMWR);
        step("sw_memwr1", 4'd6, V_MEMWR);
        rst_n = 1'b0;
        #1;
        check("sw_midrst", 4'd0, V_ZERO);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        step("post_rst", 4'd0, V_ZERO);

        // illegal opcode
        opcode = 6'h3F;
        step("ill_fetch", 4'd1, V_FETCH);
        opcode = 6'h3F;
        step("ill_decode", 4'd2, V_DECODE);
        opcode = 6'h00;
`ifdef ILLEGAL_TRAP_EN
        step("ill_trap0", 4'd13, V_TRAP);
        step("ill_trap1", 4'd13, V_TRAP);
        step("ill_trap2", 4'd13, V_TRAP);
        rst_n = 1'b0;
        #1;
        check("ill_trap_rst", 4'd0, V_ZERO);
`else
        step("ill_pulse", 4'd1, V_FETCH_I);
        step("ill_after", 4'd2, V_DECODE);
        step("ill_resume", 4'd7, V_REXEC);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_main_ctrl.md
Name: mips_main_ctrl

Overview:
- Multicycle MIPS main control FSM, on the issuing side of the ALU-control interface.
- Decodes the 6-bit opcode from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives every datapath enable, and drives the 3-bit alu_op code that the ALU control decoder combines with the funct field to pick the ALU operation.
- Stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of the state debug port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instruction bits [31:26] from the IR; sampled in DECODE
- mem_ready  input  1  memory has completed the current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (beq)
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  register write data: 0=ALUOut, 1=MDR
- reg_dst  output  1  destination register: 0=rt, 1=rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A input: 0=PC, 1=rs
- alu_src_b  output  2  ALU B input: 0=rt, 1=constant 4, 2=sign-extended imm, 3=sign-extended imm<<2
- pc_source  output  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target
- alu_op  output  3  0=add, 1=sub, 2=use funct, 3=and, 4=or, 5=slt
- illegal_op  output  1  unknown opcode detected
- state  output  STATE_W  current state (debug)

Behaviour:
- Reset:
  - rst_n low asynchronously forces state=RST (0).
  - In RST all outputs are 0, including alu_op=0 and illegal_op=0.
  - First rising edge with rst_n high moves RST->FETCH.
  - Reset mid-instruction abandons the instruction immediately; no write strobe remains asserted.
- Output decode:
  - Outputs are Moore-decoded from state, except ir_write and pc_write in FETCH, which are gated by mem_ready.
  - Any output not listed for a state is 0.
- FETCH (1):
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE (2):
  - alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute).
  - Next state by opcode:
    - 0x00 -> REXEC
    - 0x23 or 0x2B -> MEMADR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08, 0x0C, 0x0D, 0x0A -> IEXEC
    - any other opcode -> ILLEGAL handling (see Optional Feature)
- MEMADR (3): alu_src_a=1, alu_src_b=2, alu_op=0. Next: MEMRD if opcode=0x23, else MEMWR.
- MEMRD (4): mem_read=1, iord=1. Holds until mem_ready=1, then MEMWB.
- MEMWB (5): reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEMWR (6): mem_write=1, iord=1. Holds until mem_ready=1, then FETCH.
- REXEC (7): alu_src_a=1, alu_src_b=0, alu_op=2. Next: RWB.
- RWB (8): reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH (9): alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Next: FETCH.
- JUMP (10): pc_write=1, pc_source=2. Next: FETCH.
- IEXEC (11):
  - alu_src_a=1, alu_src_b=2.
  - alu_op: 0 for 0x08, 3 for 0x0C, 4 for 0x0D, 5 for 0x0A.
  - Opcode is latched into an internal register in DECODE, so later IR changes are ignored.
  - Next: IWB.
- IWB (12): reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- Instruction latency with mem_ready held 1, in cycles from entering FETCH:
  - lw 5
  - sw, R-type, I-type ALU 4
  - beq, j 3
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Decisions that depend on opcode after DECODE (MEMADR, IEXEC) use the latched copy.
- mem_ready is ignored in all states except FETCH, MEMRD and MEMWR.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to TRAP (13).
  - TRAP: all strobes 0, illegal_op=1; stays in TRAP until rst_n is asserted.
- Undefined:
  - An unknown opcode is executed as a NOP: DECODE->FETCH.
  - illegal_op pulses 1 for exactly the cycle after DECODE (the following FETCH).
  - TRAP is unreachable.

Test Plan:
- Reset/start: rst_n=0 for 3 cycles, then 1 with mem_ready=1 -> all outputs 0 during reset; state=1 and mem_read=1 one edge after release.
- lw: opcode=0x23, mem_ready=1 -> states 1,2,3,4,5,1; alu_op=0 in FETCH/DECODE/MEMADR; reg_write=1 and mem_to_reg=1 only in state 5.
- R-type plus stall: opcode=0x00, mem_ready=0 for 2 cycles in FETCH -> FETCH lasts 3 cycles with ir_write=0,0,1; REXEC shows alu_op=2; RWB shows reg_dst=1, reg_write=1.
- I-type and branch: opcodes 0x0D, 0x0A, 0x04 back to back -> IEXEC alu_op=4 then 5; BRANCH alu_op=1, pc_write_cond=1, pc_source=1; beq total 3 cycles.
- sw stall then mid-op reset: opcode=0x2B with mem_ready=0 in MEMWR -> mem_write held 1; rst_n=0 mid-MEMWR -> mem_write=0 immediately, state=0.
- Illegal opcode: opcode=0x3F
  - With ILLEGAL_TRAP_EN -> state=13, illegal_op=1 held until reset.
  - Without -> one-cycle illegal_op pulse, FETCH resumes.
